// File: rtl/mem_scan_checker.sv
// Post-run RAM checker: walks WORDS words from BASE_WORD, compares each against an expected image.
// Define MEM_CHECK_STOP_ON_FIRST_EN to end the scan at the first mismatching word.
module mem_scan_checker #(
  parameter int WORDS     = 256,
  parameter int BASE_WORD = 0,
  parameter int AW        = 16,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [AW-1:0] exp_addr,
  input  logic [31:0]   exp_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] err_idx,
  output logic [31:0]   err_got,
  output logic [31:0]   err_exp
);

  // Handshake: start is a level sampled only in IDLE/DONE; no backpressure on the RAM side,
  // read data and expected data are both valid exactly one cycle after the address register.

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST    = AW'(WORDS - 1);
  localparam logic [AW-1:0] BASE    = AW'(BASE_WORD);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_nx;
  logic [AW-1:0] idx;
  logic          cmp_v;
  logic [AW-1:0] cmp_idx;
  logic          mis;
  logic          last_issue;
  logic          stop_hit;
  logic          finish;

  assign exp_addr   = idx;
  assign mis        = cmp_v && (mem_rdata != exp_data);
  assign last_issue = (idx == LAST);
  assign finish     = ((state == SCAN) || (state == DRAIN)) && (state_nx == DONE);

`ifdef MEM_CHECK_STOP_ON_FIRST_EN
  assign stop_hit = mis;
`else
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = SCAN;
      SCAN: begin
        if (stop_hit)        state_nx = DONE;
        else if (last_issue) state_nx = DRAIN;
      end
      // DRAIN holds exactly the final in-flight compare
      DRAIN: if (stop_hit || cmp_v) state_nx = DONE;
      DONE:  if (start) state_nx = SCAN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      mem_addr <= '0;
      mem_re   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      err_idx  <= '0;
      err_got  <= '0;
      err_exp  <= '0;
      cmp_v    <= 1'b0;
      cmp_idx  <= '0;
    end else begin
      state   <= state_nx;
      cmp_v   <= mem_re && !stop_hit;
      cmp_idx <= idx;

      if (mis) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) begin
          err_idx <= cmp_idx;
          err_got <= mem_rdata;
          err_exp <= exp_data;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx      <= '0;
            mem_addr <= BASE;
            mem_re   <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_idx  <= '0;
            err_got  <= '0;
            err_exp  <= '0;
          end
        end
        SCAN: begin
          if (last_issue || stop_hit) begin
            mem_re <= 1'b0;
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: ;
      endcase

      // mis is folded in because err_cnt only reflects it after this edge
      if (finish) begin
        done   <= 1'b1;
        busy   <= 1'b0;
        mem_re <= 1'b0;
        pass   <= (err_cnt == '0) && !mis;
      end
    end
  end

endmodule

// File: tb/tb_mem_scan_checker.sv
// Directed bench for mem_scan_checker: main window, saturating counter, and address wrap instances.
// Expectations switch on MEM_CHECK_STOP_ON_FIRST_EN where the early-stop behaviour differs.
module tb_mem_scan_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // main instance: WORDS=8, BASE_WORD=16
  logic        start;
  logic        mem_re, busy, done, pass;
  logic [15:0] mem_addr, exp_addr, err_cnt, err_idx;
  logic [31:0] mem_rdata, exp_data, err_got, err_exp;
  logic [31:0] ram_img [8];
  logic [31:0] exp_img [8];

  mem_scan_checker #(.WORDS(8), .BASE_WORD(16), .AW(16), .CW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .err_idx(err_idx), .err_got(err_got), .err_exp(err_exp)
  );

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram_img[3'(mem_addr - 16'd16)];
    exp_data <= exp_img[exp_addr[2:0]];
  end

  // saturation instance: CW=2, every word wrong
  logic        start_s, mem_re_s, busy_s, done_s, pass_s;
  logic [15:0] mem_addr_s, exp_addr_s, err_idx_s;
  logic [1:0]  err_cnt_s;
  logic [31:0] mem_rdata_s, exp_data_s, err_got_s, err_exp_s;

  mem_scan_checker #(.WORDS(8), .BASE_WORD(0), .AW(16), .CW(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .mem_re(mem_re_s), .mem_addr(mem_addr_s), .mem_rdata(mem_rdata_s),
    .exp_addr(exp_addr_s), .exp_data(exp_data_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
    .err_idx(err_idx_s), .err_got(err_got_s), .err_exp(err_exp_s)
  );

  always @(posedge clk) begin
    if (mem_re_s) mem_rdata_s <= ~{16'h0, mem_addr_s};
    exp_data_s <= {16'h0, exp_addr_s};
  end

  // wrap instance: BASE_WORD=0xFFFE, WORDS=4
  logic        start_w, mem_re_w, busy_w, done_w, pass_w;
  logic [15:0] mem_addr_w, exp_addr_w, err_cnt_w, err_idx_w;
  logic [31:0] mem_rdata_w, exp_data_w, err_got_w, err_exp_w;

  mem_scan_checker #(.WORDS(4), .BASE_WORD(16'hFFFE), .AW(16), .CW(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w),
    .mem_re(mem_re_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
    .exp_addr(exp_addr_w), .exp_data(exp_data_w),
    .busy(busy_w), .done(done_w), .pass(pass_w), .err_cnt(err_cnt_w),
    .err_idx(err_idx_w), .err_got(err_got_w), .err_exp(err_exp_w)
  );

  always @(posedge clk) begin
    if (mem_re_w) mem_rdata_w <= {16'h0, mem_addr_w};
    exp_data_w <= {16'h0, exp_addr_w + 16'hFFFE};
  end

  // issued-address scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] got_w_q[$];

  always @(negedge clk) begin
    if (mem_re)   got_q.push_back(mem_addr);
    if (mem_re_w) got_w_q.push_back(mem_addr_w);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_done(input int sel);
    case (sel)
      1:       return done_s;
      2:       return done_w;
      default: return done;
    endcase
  endfunction

  // leaves the bench at the negedge following E0
  task automatic start_pulse(input int sel);
    @(negedge clk);
    case (sel)
      1:       start_s = 1'b1;
      2:       start_w = 1'b1;
      default: start   = 1'b1;
    endcase
    @(negedge clk);
    start = 1'b0; start_s = 1'b0; start_w = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int lat0, output int lat);
    lat = lat0;
    while (!cur_done(sel) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_re"},   mem_re,   0);
    check({pfx, "_mem_addr"}, mem_addr, 0);
    check({pfx, "_exp_addr"}, exp_addr, 0);
    check({pfx, "_busy"},     busy,     0);
    check({pfx, "_done"},     done,     0);
    check({pfx, "_pass"},     pass,     0);
    check({pfx, "_err_cnt"},  err_cnt,  0);
    check({pfx, "_err_idx"},  err_idx,  0);
    check({pfx, "_err_got"},  err_got,  0);
    check({pfx, "_err_exp"},  err_exp,  0);
  endtask

  task automatic check_mismatch_result(input string pfx, input int lat);
`ifdef MEM_CHECK_STOP_ON_FIRST_EN
    check({pfx, "_lat"},     lat,     5);
    check({pfx, "_err_cnt"}, err_cnt, 1);
    check({pfx, "_mem_re"},  mem_re,  0);
`else
    check({pfx, "_lat"},     lat,     9);
    check({pfx, "_err_cnt"}, err_cnt, 2);
`endif
    check({pfx, "_pass"},    pass,    0);
    check({pfx, "_err_idx"}, err_idx, 3);
    check({pfx, "_err_got"}, err_got, 32'hDEADBEEF);
    check({pfx, "_err_exp"}, err_exp, 32'h00000003);
  endtask

  initial begin
    int lat;
    start = 1'b0; start_s = 1'b0; start_w = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ram_img[i] = 32'(i);
      exp_img[i] = 32'(i);
    end

    // reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // clean window
    got_q.delete();
    start_pulse(0);
    check("clean_busy_e0", busy, 1);
    check("clean_exp_addr_e0", exp_addr, 0);
    wait_done(0, 0, lat);
    check("clean_lat", lat, 9);
    check("clean_pass", pass, 1);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_busy_done", busy, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(16 + i));
    check("clean_addr_count", got_q.size(), 8);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("clean_addr", got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    @(negedge clk);
    check("done_held", done, 1);

    // two mismatching words
    ram_img[3] = 32'hDEADBEEF;
    ram_img[6] = 32'h66666666;
    start_pulse(0);
    wait_done(0, 0, lat);
    check_mismatch_result("mis", lat);

    // reset in mid-scan, then restart with a stray start in SCAN
    start_pulse(0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_re", mem_re, 0);
    start_pulse(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 2, lat);
    check_mismatch_result("rescan", lat);

    // start held high through DONE re-triggers
    ram_img[3] = 32'h3;
    ram_img[6] = 32'h6;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(0, 0, lat);
    check("hold_lat1", lat, 9);
    check("hold_pass1", pass, 1);
    @(negedge clk);
    check("hold_retrig_done", done, 0);
    check("hold_retrig_busy", busy, 1);
    start = 1'b0;
    wait_done(0, 0, lat);
    check("hold_lat2", lat, 9);
    check("hold_pass2", pass, 1);

    // saturating counter
    start_pulse(1);
    wait_done(1, 0, lat);
`ifdef MEM_CHECK_STOP_ON_FIRST_EN
    check("sat_lat", lat, 2);
    check("sat_err_cnt", err_cnt_s, 1);
`else
    check("sat_lat", lat, 9);
    check("sat_err_cnt", err_cnt_s, 3);
`endif
    check("sat_pass", pass_s, 0);
    check("sat_err_idx", err_idx_s, 0);
    check("sat_err_got", err_got_s, 32'hFFFFFFFF);
    check("sat_err_exp", err_exp_s, 32'h0);

    // address wrap
    got_w_q.delete();
    start_pulse(2);
    wait_done(2, 0, lat);
    check("wrap_lat", lat, 5);
    check("wrap_pass", pass_w, 1);
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    check("wrap_addr_count", got_w_q.size(), 4);
    while (exp_q.size() > 0 && got_w_q.size() > 0)
      check("wrap_addr", got_w_q.pop_front(), exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_scan_checker.md
# mem_scan_checker

Synthesizable post-run memory checker for the MIPS32 cores. It sits directly downstream of the CPU's data RAM: once the program has halted, it walks a window of RAM words through a synchronous read port, compares each against an expected-image port, and reports pass/fail, mismatch count and first-mismatch details. It replaces fixed-delay end-of-simulation memory dumps and can run on FPGA.

## Interface
- `WORDS`, 256: number of 32-bit words to check; at least 1.
- `BASE_WORD`, 0: word index of the first checked RAM word (the data segment offset, (DATA-TEXT)/4).
- `AW`, 16: width of word-index address outputs.
- `CW`, 16: width of mismatch counter.

Ports (clock and reset first):
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin scan; sampled only in IDLE or DONE.
- `mem_re` out 1: RAM read enable.
- `mem_addr` out AW: RAM word index = BASE_WORD + idx.
- `mem_rdata` in 32: RAM data, valid one cycle after `mem_addr`/`mem_re` are sampled.
- `exp_addr` out AW: expected-image word index = idx (0-based).
- `exp_data` in 32: expected word; same one-cycle latency.
- `busy` out 1: scan in progress.
- `done` out 1: scan finished; held until the next start or reset.
- `pass` out 1: valid when `done`; 1 when no mismatch was found.
- `err_cnt` out CW: number of mismatching words, saturating at 2^CW-1.
- `err_idx` out AW: idx of the first mismatch.
- `err_got` out 32: RAM value at the first mismatch.
- `err_exp` out 32: expected value at the first mismatch.

## Operation
- States are IDLE, SCAN, DRAIN and DONE.
- IDLE or DONE with `start`=1 goes to SCAN. On that edge: idx=0, `mem_re`=1, `mem_addr`=BASE_WORD, `exp_addr`=0, `err_cnt`=0, `done`=0, `pass`=0, and error fields are cleared.
- In SCAN, each edge advances idx and issues the next address. After issuing idx=WORDS-1, the state moves to DRAIN and `mem_re` drops.
- Compare stage: a valid bit is delayed one cycle behind each issued read, along with its idx. At the edge after data return, the block compares `mem_rdata` with `exp_data`; any bit difference is a mismatch.
- On a mismatch: `err_cnt` increments, saturating. If this is the first mismatch, `err_idx`, `err_got` and `err_exp` are latched.
- DRAIN goes to DONE when the last compare completes. On that edge `done`=1 and `pass`=(no mismatch seen), and `busy` falls.
- `start` in SCAN or DRAIN is ignored.
- Address arithmetic is modulo 2^AW. Wrap-around of BASE_WORD+idx is permitted and not flagged.

## Timing
- Reset values: state IDLE; all outputs 0 (`mem_re`, `mem_addr`, `exp_addr`, `busy`, `done`, `pass`, `err_cnt`, `err_idx`, `err_got`, `err_exp`).
- Take the start edge as E0. Address k is registered at edge Ek, and its compare result is registered at edge E(k+2).
- `done` rises at edge E(WORDS+1). `busy` is high from E0 to E(WORDS+1).
- Throughput is one word per cycle with no stalls.
- WORDS=1: `done` at E2.
- Reset mid-scan: returns immediately to reset values. The in-flight read is discarded, and the next scan requires a new `start`.
- `start` held high continuously in DONE re-triggers a scan on every entry to DONE.

## Configuration
- `MEM_CHECK_STOP_ON_FIRST_EN` defined: the first mismatch ends the scan. The compare edge that detects it goes straight to DONE with `done`=1, `pass`=0 and `err_cnt`=1. The in-flight read is discarded and `mem_re` drops on the same edge.
- Not defined: the full window is always scanned and `err_cnt` counts every mismatch.

## Test plan
- WORDS=8, RAM matches the expected image; pulse `start` at E0. Required: `done`=1, `pass`=1, `err_cnt`=0 at E9; `mem_addr` takes BASE_WORD..BASE_WORD+7 on consecutive cycles.
- WORDS=8, RAM idx 3 = 0xDEADBEEF vs expected 0x00000003, and idx 6 also differs. Without the macro: `done` at E9, `pass`=0, `err_cnt`=2, `err_idx`=3, `err_got`=0xDEADBEEF, `err_exp`=0x00000003.
- Same stimulus with `MEM_CHECK_STOP_ON_FIRST_EN`. Required: `done` at E5, `err_cnt`=1, `err_idx`=3, `mem_re`=0 from E5.
- Assert `rst_n`=0 at E4 mid-scan, then release and pulse `start`. Required: all outputs 0 during reset, and the second scan completes with correct results; extra `start` pulses in SCAN have no effect.
- CW=2, WORDS=8 with all words wrong. Required: `err_cnt` saturates at 3, `err_idx`=0.
- BASE_WORD=0xFFFE, AW=16, WORDS=4. Required: `mem_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
